// File: rtl/img_pkg.sv
// img_pkg: shared definitions for the image point-processing slice.
//   - mode encodings for the point operation select
//   - controller state enum
//   - point_op(): the per-pixel transfer function. It is written at OP_W bits
//     so one function serves any PIX_W up to OP_W. Callers zero-extend the
//     pixel and parameter, pass the all-ones pixel value as maxv, and
//     truncate the result back to PIX_W.
package img_pkg;

  localparam int OP_W = 16;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_NEG  = 2'd1;
  localparam logic [1:0] MODE_THR  = 2'd2;
  localparam logic [1:0] MODE_BRT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PROC = 2'd2
  } state_t;

  function automatic logic [OP_W-1:0] point_op(
    input logic [1:0]      mode,
    input logic [OP_W-1:0] p,
    input logic [OP_W-1:0] param,
    input logic [OP_W-1:0] maxv
  );
    logic [OP_W:0] sum;
    // One extra bit so the brightness add cannot wrap before the clamp.
    sum = {1'b0, p} + {1'b0, param};
    case (mode)
      MODE_PASS: point_op = p;
      MODE_NEG:  point_op = maxv - p;
      MODE_THR:  point_op = (p >= param) ? maxv : '0;
      default:   point_op = (sum > {1'b0, maxv}) ? maxv : sum[OP_W-1:0];
    endcase
  endfunction

endpackage

// File: rtl/img_ram.sv
// img_ram: frame buffer with one write port and two independent read ports.
// Both reads are registered (1-cycle latency). The read registers reset to 0
// so the host data path is defined out of reset; the array is not cleared.
// Ports:
//   clk, reset      clock, async active-low reset (read registers only)
//   we/waddr/wdata  write port
//   ra_addr/ra_data read port A
//   rb_addr/rb_data read port B
module img_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] ra_addr,
  output logic [W-1:0]  ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [W-1:0]  rb_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ra_data <= '0;
      rb_data <= '0;
    end else begin
      ra_data <= mem[ra_addr];
      rb_data <= mem[rb_addr];
    end
  end

endmodule

// File: rtl/image_point_proc.sv
// image_point_proc: receives one IMG_W x IMG_H frame as a raster-order pixel
// stream into the original-image memory, then on start applies a point
// operation (pass / negative / threshold / saturating brightness) to every
// pixel into the processed-image memory.
// Ports:
//   clk, reset            clock, async active-low reset
//   in_valid/in_data      pixel stream; in_ready is high in IDLE and LOAD
//   start/mode/param      begin a processing pass (mode/param latched)
//   rd_sel/rd_addr        host read: 0 = original, 1 = processed memory
//   rd_data               host read data, 1-cycle latency
//   busy                  high in LOAD or PROC
//   img_loaded            sticky: a full frame has been received
//   proc_done             sticky: a processing pass has completed
//   pix_min/pix_max       running min/max of the loaded frame
//                         (present only when IMG_MINMAX_EN is defined)
// PROC pipeline: stage 0 reads original memory at proc_cnt, stage 1 writes
// the op result at the delayed address, stage 2 marks the last write and
// raises proc_done; a pass takes NPIX+2 cycles from the start edge.
module image_point_proc
  import img_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int NPIX   = IMG_W * IMG_H,
  parameter int ADDR_W = $clog2(NPIX)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [PIX_W-1:0]  in_data,
  output logic              in_ready,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [PIX_W-1:0]  param,
  input  logic              rd_sel,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              busy,
  output logic              img_loaded,
  output logic              proc_done
`ifdef IMG_MINMAX_EN
  ,
  output logic [PIX_W-1:0]  pix_min,
  output logic [PIX_W-1:0]  pix_max
`endif
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);
  localparam logic [OP_W-1:0]   MAXV = OP_W'({PIX_W{1'b1}});

  state_t              state;
  logic [ADDR_W-1:0]   load_cnt;
  logic [ADDR_W-1:0]   proc_cnt;
  logic [ADDR_W-1:0]   addr_d;
  logic [2:0]          vld_pipe;
  logic [1:0]          mode_q;
  logic [PIX_W-1:0]    param_q;
  logic                rd_sel_q;

  logic                orig_we;
  logic [ADDR_W-1:0]   orig_waddr;
  logic [PIX_W-1:0]    orig_proc_rd;
  logic [PIX_W-1:0]    orig_host_rd;
  logic [PIX_W-1:0]    proc_host_rd;
  logic [PIX_W-1:0]    proc_wdata;
  logic [PIX_W-1:0]    proc_rd_unused;

  assign in_ready = (state != ST_PROC);
  assign busy     = (state != ST_IDLE);

  // The first pixel of a frame is accepted from IDLE and always lands at 0.
  assign orig_we    = in_valid && (state != ST_PROC);
  assign orig_waddr = (state == ST_IDLE) ? '0 : load_cnt;

  assign proc_wdata = PIX_W'(point_op(mode_q, OP_W'(orig_proc_rd),
                                      OP_W'(param_q), MAXV));

  assign rd_data = rd_sel_q ? proc_host_rd : orig_host_rd;

  img_ram #(.W(PIX_W), .DEPTH(NPIX), .AW(ADDR_W)) u_orig (
    .clk     (clk),
    .reset   (reset),
    .we      (orig_we),
    .waddr   (orig_waddr),
    .wdata   (in_data),
    .ra_addr (proc_cnt),
    .ra_data (orig_proc_rd),
    .rb_addr (rd_addr),
    .rb_data (orig_host_rd)
  );

  // Only one read port of the processed copy is needed (host side).
  img_ram #(.W(PIX_W), .DEPTH(NPIX), .AW(ADDR_W)) u_proc (
    .clk     (clk),
    .reset   (reset),
    .we      (vld_pipe[1]),
    .waddr   (addr_d),
    .wdata   (proc_wdata),
    .ra_addr (addr_d),
    .ra_data (proc_rd_unused),
    .rb_addr (rd_addr),
    .rb_data (proc_host_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      load_cnt   <= '0;
      proc_cnt   <= '0;
      addr_d     <= '0;
      vld_pipe   <= '0;
      mode_q     <= MODE_PASS;
      param_q    <= '0;
      rd_sel_q   <= 1'b0;
      img_loaded <= 1'b0;
      proc_done  <= 1'b0;
    end else begin
      rd_sel_q    <= rd_sel;
      addr_d      <= proc_cnt;
      vld_pipe[1] <= vld_pipe[0];
      vld_pipe[2] <= vld_pipe[1] && (addr_d == LAST);
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            // A pixel takes priority over a coincident start.
            load_cnt   <= ADDR_W'(1);
            img_loaded <= 1'b0;
            proc_done  <= 1'b0;
            state      <= ST_LOAD;
          end else if (start && img_loaded) begin
            mode_q      <= mode;
            param_q     <= param;
            proc_cnt    <= '0;
            proc_done   <= 1'b0;
            vld_pipe[0] <= 1'b1;
            state       <= ST_PROC;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (load_cnt == LAST) begin
              img_loaded <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        ST_PROC: begin
          if (vld_pipe[0]) begin
            if (proc_cnt == LAST) vld_pipe[0] <= 1'b0;
            else                  proc_cnt    <= proc_cnt + 1'b1;
          end
          if (vld_pipe[2]) begin
            proc_done <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef IMG_MINMAX_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_min <= '0;
      pix_max <= '0;
    end else if (in_valid && state == ST_IDLE) begin
      // First pixel of a new frame seeds both trackers.
      pix_min <= in_data;
      pix_max <= in_data;
    end else if (in_valid && state == ST_LOAD) begin
      if (in_data < pix_min) pix_min <= in_data;
      if (in_data > pix_max) pix_max <= in_data;
    end
  end
`endif

endmodule

// File: tb/tb_image_point_proc.sv
module tb_image_point_proc;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       start = 1'b0;
  logic [1:0] mode = '0;
  logic [7:0] param = '0;
  logic       rd_sel = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       busy;
  logic       img_loaded;
  logic       proc_done;
`ifdef IMG_MINMAX_EN
  logic [7:0] pix_min;
  logic [7:0] pix_max;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] orig_m [N];
  logic [7:0] proc_m [N];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  image_point_proc #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .start      (start),
    .mode       (mode),
    .param      (param),
    .rd_sel     (rd_sel),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .img_loaded (img_loaded),
    .proc_done  (proc_done)
`ifdef IMG_MINMAX_EN
    ,
    .pix_min    (pix_min),
    .pix_max    (pix_max)
`endif
  );

  function automatic logic [7:0] m_op(input int md, input int p, input int prm);
    case (md)
      0: return 8'(p);
      1: return 8'(255 - p);
      2: return (p >= prm) ? 8'hFF : 8'h00;
      default: return (p + prm > 255) ? 8'hFF : 8'(p + prm);
    endcase
  endfunction

  // Stream n pixels of orig_m; optionally raise start with the first one
  // (and again mid-stream) to exercise the priority / ignore rules.
  task automatic stream(input int n, input bit start_too);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = orig_m[i];
      start    = start_too && (i == 0 || i == 5);
      mode     = 2'd1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Issue a host read and queue what it must return.
  task automatic rd_req(input logic sel, input int addr, input logic [7:0] e);
    rd_sel  = sel;
    rd_addr = 4'(addr);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Run one processing pass, counting cycles and poking in_valid meanwhile.
  task automatic run_proc(input int md, input int prm);
    int cyc;
    for (int i = 0; i < N; i++) proc_m[i] = m_op(md, orig_m[i], prm);
    mode  = 2'(md);
    param = 8'(prm);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode  = 2'd0;
    param = 8'h00;
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL proc_entry mode=%0d in_ready=%b busy=%b want 0/1", md, in_ready, busy);
    end
    cyc = 0;
    while (proc_done !== 1'b1 && cyc < 100) begin
      in_valid = (cyc < 4);
      in_data  = 8'hAA;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    vectors++;
    if (cyc !== N + 2 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL proc_latency mode=%0d got %0d cycles busy=%b want %0d busy=0", md, cyc, busy, N + 2);
    end
  endtask

  task automatic check_mem(input logic sel, input string nm);
    logic [7:0] e;
    for (int i = 0; i < N; i++) begin
      rd_req(sel, i, sel ? proc_m[i] : orig_m[i]);
      e = exp_q.pop_front();
      vectors++;
      if (rd_data !== e) begin
        miscompares++;
        $display("FAIL %s addr=%0d got %h want %h", nm, i, rd_data, e);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({in_ready, busy, img_loaded, proc_done} !== 4'b1000 || rd_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset rdy/busy/ld/done=%b rd_data=%h want 1000 00",
               {in_ready, busy, img_loaded, proc_done}, rd_data);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    start = 1'b1;
    mode  = 2'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || proc_done !== 1'b0) begin
      miscompares++;
      $display("FAIL start_no_image busy=%b rdy=%b done=%b want 0 1 0", busy, in_ready, proc_done);
    end
  endtask

  task automatic test_load();
    logic [7:0] e;
    for (int i = 0; i < N; i++) orig_m[i] = 8'(i);
    stream(N, 1'b1);
    vectors++;
    if (img_loaded !== 1'b1 || busy !== 1'b0 || proc_done !== 1'b0) begin
      miscompares++;
      $display("FAIL load_flags ld=%b busy=%b done=%b want 1 0 0", img_loaded, busy, proc_done);
    end
    rd_req(1'b0, 5, 8'h05);
    e = exp_q.pop_front();
    vectors++;
    if (rd_data !== e) begin
      miscompares++;
      $display("FAIL orig_addr5 got %h want %h", rd_data, e);
    end
    check_mem(1'b0, "orig_after_load");
  endtask

  task automatic test_negative();
    run_proc(1, 0);
    check_mem(1'b1, "neg");
    // orig must not be touched by in_valid during PROC
    check_mem(1'b0, "orig_after_proc");
  endtask

  task automatic test_reload_keeps_proc();
    orig_m[0] = 8'h80;
    orig_m[1] = 8'h7F;
    orig_m[2] = 8'hF0;
    orig_m[3] = 8'h10;
    for (int i = 4; i < N; i++) orig_m[i] = 8'($urandom);
    stream(N, 1'b0);
    vectors++;
    if (img_loaded !== 1'b1 || proc_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reload_flags ld=%b done=%b want 1 0", img_loaded, proc_done);
    end
    check_mem(1'b1, "proc_kept_over_load");
  endtask

  task automatic test_point_ops();
    run_proc(2, 8'h80);
    check_mem(1'b1, "thr");
    run_proc(3, 8'h20);
    check_mem(1'b1, "brt");
    run_proc(0, 8'h55);
    check_mem(1'b1, "pass");
  endtask

  task automatic test_abort_reload();
    for (int i = 0; i < N; i++) orig_m[i] = 8'(8'hC0 - i);
    stream(8, 1'b1);
    vectors++;
    if ({busy, in_ready, img_loaded, proc_done} !== 4'b1100) begin
      miscompares++;
      $display("FAIL collision busy/rdy/ld/done=%b want 1100", {busy, in_ready, img_loaded, proc_done});
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({busy, in_ready, img_loaded, proc_done} !== 4'b0100) begin
      miscompares++;
      $display("FAIL abort busy/rdy/ld/done=%b want 0100", {busy, in_ready, img_loaded, proc_done});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) orig_m[i] = 8'($urandom);
    stream(N, 1'b0);
    vectors++;
    if (img_loaded !== 1'b1) begin
      miscompares++;
      $display("FAIL reload_after_abort ld=%b want 1", img_loaded);
    end
    check_mem(1'b0, "orig_reload");
    run_proc(3, 8'h40);
    check_mem(1'b1, "brt_reload");
  endtask

`ifdef IMG_MINMAX_EN
  task automatic test_minmax();
    orig_m[0] = 8'd7;
    orig_m[1] = 8'd3;
    orig_m[2] = 8'd250;
    orig_m[3] = 8'd9;
    for (int i = 4; i < N; i++) orig_m[i] = 8'(10 + i * 5);
    stream(N, 1'b0);
    vectors++;
    if (pix_min !== 8'd3 || pix_max !== 8'd250 || img_loaded !== 1'b1) begin
      miscompares++;
      $display("FAIL minmax min=%0d max=%0d ld=%b want 3 250 1", pix_min, pix_max, img_loaded);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start_ignored();
    test_load();
    test_negative();
    test_reload_keeps_proc();
    test_point_ops();
    test_abort_reload();
`ifdef IMG_MINMAX_EN
    test_minmax();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
